rr_arbiter_4: RTL

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

---
 rtl/rr_arbiter_4.sv | 139 +++++++++++++
 1 files changed

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with one-cycle grant latency and a mandatory idle cycle between grants.
// Optional hold timeout compiled in with `define ARB_TIMEOUT_EN (limit set by MAX_HOLD).
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned HOLD_W  = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Out-of-range hold limits cannot be represented by the 8-bit hold counter.
    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
        $error("rr_arbiter_4: MAX_HOLD must be in 2..256");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0]   pick_c;
    logic               pick_found_c;

`ifdef ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               timeout_q, timeout_d;
`endif

    // First requester found when searching upward from the priority pointer.
    always_comb begin
        pick_c       = ptr_q;
        pick_found_c = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found_c && req[ptr_q + IDX_W'(k)]) begin
                pick_c       = ptr_q + IDX_W'(k);
                pick_found_c = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found_c) begin
                    state_d     = ST_GRANT;
                    gnt_idx_d   = pick_c;
                    gnt_d       = NUM_REQ'(1) << pick_c;
                    gnt_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d  = '0;
`endif
                end
            end
            ST_GRANT: begin
                // Voluntary release wins over a simultaneous timeout.
                if (!req[gnt_idx_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = gnt_idx_q + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
                end else if (hold_cnt_q == HOLD_LIMIT) begin
                    state_d   = ST_IDLE;
                    ptr_d     = gnt_idx_q + IDX_W'(1);
                    timeout_d = 1'b1;
`endif
                end else begin
                    gnt_d       = gnt_q;
                    gnt_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d  = hold_cnt_q + HOLD_W'(1);
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule
